// File: rtl/kyber_pkg.sv
// Shared Kyber constants and the coefficient-loader FSM state type.
package kyber_pkg;

    localparam int unsigned KYBER_Q     = 3329;
    localparam int unsigned KYBER_ETA   = 2;
    localparam int unsigned KYBER_N     = 256;
    localparam int unsigned KYBER_NPAIR = KYBER_N / 2;

    // Coefficient-pair RAM geometry: one word holds {odd, even} coefficient.
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StFull
    } load_state_e;

endpackage

// File: rtl/cbd_poly_load_if.sv
// Sampler-side and consumer-side signals of the CBD polynomial loader.
interface cbd_poly_load_if;

    logic               start;
    logic               cf_valid;
    logic signed [15:0] cf_in_1;
    logic signed [15:0] cf_in_2;
    logic               req;
    logic               rd_en;
    logic [6:0]         rd_addr;
    logic [15:0]        rd_dout_1;
    logic [15:0]        rd_dout_2;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output start, cf_valid, cf_in_1, cf_in_2, rd_en, rd_addr,
        input  req, rd_dout_1, rd_dout_2, busy, done, err
    );

    modport slave (
        input  start, cf_valid, cf_in_1, cf_in_2, rd_en, rd_addr,
        output req, rd_dout_1, rd_dout_2, busy, done, err
    );

endinterface

// File: rtl/dual_ram.sv
// Simple dual-port RAM: port 1 writes, port 2 reads with a registered output.
module dual_ram #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] din1,
    input  logic              en2,
    input  logic [ADDR_W-1:0] addr2,
    output logic [DATA_W-1:0] dout2
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write port: storage itself is not reset.
    always_ff @(posedge clk) begin
        if (we1) begin
            mem[addr1] <= din1;
        end
    end

    // Read port: output register holds its value between enabled reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout2 <= '0;
        end else if (en2) begin
            dout2 <= mem[addr2];
        end
    end

endmodule

// File: rtl/cbd_poly_load.sv
// Captures CBD-sampled coefficient pairs, reduces them into [0,Q) and serves
// them to a downstream consumer from a pair-wide RAM.
module cbd_poly_load
    import kyber_pkg::*;
#(
    parameter int unsigned Q     = KYBER_Q,
    parameter int unsigned ETA   = KYBER_ETA,
    parameter int unsigned NPAIR = KYBER_NPAIR
) (
    input logic            clk,
    input logic            reset,
    cbd_poly_load_if.slave bus
);

    localparam logic [15:0]        Q16     = 16'(Q);
    localparam logic signed [15:0] EtaHi   = 16'(ETA);
    localparam logic signed [15:0] EtaLo   = -EtaHi;
    localparam logic [ADDR_W-1:0]  LastPtr = ADDR_W'(NPAIR - 1);

    load_state_e       state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              err_q, err_d;
    logic              wr_en;
    logic              rd_go;
    logic [15:0]       red_1, red_2;
    logic              bad_1, bad_2;
    logic [DATA_W-1:0] rd_word;

    // Negative samples map to c+Q; non-negative samples pass unchanged.
    assign red_1 = bus.cf_in_1[15] ? ($unsigned(bus.cf_in_1) + Q16) : $unsigned(bus.cf_in_1);
    assign red_2 = bus.cf_in_2[15] ? ($unsigned(bus.cf_in_2) + Q16) : $unsigned(bus.cf_in_2);

    assign bad_1 = ($signed(bus.cf_in_1) < EtaLo) || ($signed(bus.cf_in_1) > EtaHi);
    assign bad_2 = ($signed(bus.cf_in_2) < EtaLo) || ($signed(bus.cf_in_2) > EtaHi);

    // Next state: start overrides everything, including a coincident pair.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        err_d    = err_q;
        wr_en    = 1'b0;
        if (bus.start) begin
            state_d  = StFill;
            wr_ptr_d = '0;
            err_d    = 1'b0;
        end else if ((state_q == StFill) && bus.cf_valid) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (bad_1 || bad_2) begin
                err_d = 1'b1;
            end
            if (wr_ptr_q == LastPtr) begin
                state_d = StFull;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            err_q    <= err_d;
        end
    end

    assign rd_go = bus.rd_en && (state_q == StFull);

    dual_ram #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram (
        .clk  (clk),
        .reset(reset),
        .we1  (wr_en),
        .addr1(wr_ptr_q),
        .din1 ({red_2, red_1}),
        .en2  (rd_go),
        .addr2(bus.rd_addr),
        .dout2(rd_word)
    );

    assign bus.rd_dout_1 = rd_word[15:0];
    assign bus.rd_dout_2 = rd_word[31:16];
    assign bus.busy      = (state_q == StFill);
    assign bus.req       = (state_q == StFill);
    assign bus.done      = (state_q == StFull);
    assign bus.err       = err_q;

endmodule

// File: tb/tb_cbd_poly_load.sv
// Directed bench for the CBD polynomial loader.
module tb_cbd_poly_load;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;

    cbd_poly_load_if bus ();

    cbd_poly_load dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int a, input int b);
        bus.cf_valid = 1'b1;
        bus.cf_in_1  = 16'(a);
        bus.cf_in_2  = 16'(b);
        tick();
        bus.cf_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic rd(input int addr);
        bus.rd_en   = 1'b1;
        bus.rd_addr = 7'(addr);
        tick();
        bus.rd_en   = 1'b0;
    endtask

    function automatic int red(input int c);
        return (c < 0) ? c + 3329 : c;
    endfunction

    initial begin
        int a;
        int b;
        int req_bad;
        bus.start    = 1'b0;
        bus.cf_valid = 1'b0;
        bus.cf_in_1  = '0;
        bus.cf_in_2  = '0;
        bus.rd_en    = 1'b0;
        bus.rd_addr  = '0;

        // Reset state
        tick();
        check("rst_busy", bus.busy, 0);
        check("rst_req", bus.req, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_dout1", bus.rd_dout_1, 0);
        check("rst_dout2", bus.rd_dout_2, 0);
        #2 reset = 1'b0;
        tick();

        // cf_valid in IDLE: no leaving IDLE, no error
        for (int i = 0; i < 3; i++) send(7, -7);
        check("idle_busy", bus.busy, 0);
        check("idle_err", bus.err, 0);

        // All pairs (-2,2) back-to-back
        pulse_start();
        check("a_busy", bus.busy, 1);
        check("a_req", bus.req, 1);
        check("a_done0", bus.done, 0);
        for (int k = 0; k < 127; k++) send(-2, 2);
        check("a_done_127", bus.done, 0);
        send(-2, 2);
        check("a_done", bus.done, 1);
        check("a_busy_end", bus.busy, 0);
        check("a_req_end", bus.req, 0);
        check("a_err", bus.err, 0);
        rd(0);
        check("a_rd0_1", bus.rd_dout_1, 3327);
        check("a_rd0_2", bus.rd_dout_2, 2);
        rd(127);
        check("a_rd127_1", bus.rd_dout_1, 3327);

        // cf_valid in FULL must not write or flag
        for (int i = 0; i < 4; i++) send(5, 1);
        check("full_done", bus.done, 1);
        check("full_err", bus.err, 0);
        tick();
        check("full_hold", bus.rd_dout_2, 2);
        rd(5);
        check("full_rd5_1", bus.rd_dout_1, 3327);
        check("full_rd5_2", bus.rd_dout_2, 2);

        // Varying pairs with gaps; req must stay high throughout FILL
        pulse_start();
        req_bad = 0;
        for (int k = 0; k < 128; k++) begin
            for (int g = 0; g < (k % 4); g++) begin
                if (bus.req !== 1'b1) req_bad++;
                tick();
            end
            if (k == 9) begin
                rd(0);
                check("fill_rd_ignored1", bus.rd_dout_1, 3327);
                check("fill_rd_ignored2", bus.rd_dout_2, 2);
            end
            if (bus.req !== 1'b1) req_bad++;
            a = (k % 5) - 2;
            send(a, -a);
        end
        check("b_req_fill", req_bad, 0);
        check("b_req_full", bus.req, 0);
        check("b_done", bus.done, 1);
        check("b_err", bus.err, 0);
        for (int k = 0; k < 128; k++) begin
            a = (k % 5) - 2;
            rd(k);
            check($sformatf("b_rd%0d_1", k), bus.rd_dout_1, red(a));
            check($sformatf("b_rd%0d_2", k), bus.rd_dout_2, red(-a));
        end

        // Out-of-range pair 10
        pulse_start();
        for (int k = 0; k < 10; k++) send(0, 0);
        check("c_err_before", bus.err, 0);
        send(3, -1);
        check("c_err_set", bus.err, 1);
        for (int k = 11; k < 128; k++) send(1, -1);
        check("c_done", bus.done, 1);
        check("c_err_full", bus.err, 1);
        rd(10);
        check("c_rd10_1", bus.rd_dout_1, 3);
        check("c_rd10_2", bus.rd_dout_2, 3328);
        rd(11);
        check("c_rd11_1", bus.rd_dout_1, 1);
        pulse_start();
        check("c_err_clr", bus.err, 0);
        check("c_done_clr", bus.done, 0);

        // Restart at pair 64 with coincident cf_valid
        for (int k = 0; k < 64; k++) send(2, -2);
        bus.start = 1'b1;
        send(2, 2);
        bus.start = 1'b0;
        check("d_busy", bus.busy, 1);
        for (int k = 0; k < 127; k++) begin
            b = (k % 3) - 1;
            send(b, -b);
        end
        check("d_done_127", bus.done, 0);
        send((127 % 3) - 1, 1 - (127 % 3));
        check("d_done", bus.done, 1);
        rd(0);
        check("d_rd0_1", bus.rd_dout_1, 3328);
        check("d_rd0_2", bus.rd_dout_2, 1);
        rd(64);
        check("d_rd64_1", bus.rd_dout_1, 0);
        rd(2);
        check("d_rd2_1", bus.rd_dout_1, 1);
        check("d_rd2_2", bus.rd_dout_2, 3328);

        // Asynchronous reset mid-FILL
        pulse_start();
        for (int k = 0; k < 50; k++) send((k == 3) ? -4 : 0, 0);
        check("e_err_pre", bus.err, 1);
        #2 reset = 1'b1;
        #1;
        check("e_busy", bus.busy, 0);
        check("e_req", bus.req, 0);
        check("e_done", bus.done, 0);
        check("e_err", bus.err, 0);
        check("e_dout1", bus.rd_dout_1, 0);
        check("e_dout2", bus.rd_dout_2, 0);
        #2 reset = 1'b0;
        for (int k = 0; k < 5; k++) send(9, 9);
        check("e_idle_busy", bus.busy, 0);
        check("e_idle_err", bus.err, 0);
        rd(2);
        check("e_idle_rd1", bus.rd_dout_1, 0);
        check("e_idle_rd2", bus.rd_dout_2, 0);
        check("e_idle_done", bus.done, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
